change_dispenser: RTL and testbench
===================================

// Module: change_dispenser
// PURPOSE
//  Downstream of the vending FSM: consumes its change amount and pays it out as physical
//  coins (20 and 10 units) through a valid/ready handshake to the coin hopper driver.
//  Keeps per-denomination coin stock, pays greedily, and flags any unpayable remainder.
//  One instance per machine, clocked with the vending FSM.
// PARAMETERS
//  W        16     width of amount/value buses (matches FSM credit width)
//  INV_W    8      width of each coin-stock counter
//  INIT_10  8'd20  stock of 10-unit coins after reset
//  INIT_20  8'd20  stock of 20-unit coins after reset
// PORTS
//  clk           in   1      system clock, rising edge
//  rst           in   1      asynchronous, active-high reset
//  change_in     in   W      change amount from FSM; nonzero for >=1 cycle per request
//  coin_valid    out  1      coin offer to hopper
//  coin_value    out  W      denomination offered: 20 or 10, 0 when coin_valid=0
//  coin_ready    in   1      hopper accepts the coin on this clock edge
//  refill_en     in   1      add refill_10/refill_20 to the stock this cycle
//  refill_10     in   INV_W  10-unit coins added
//  refill_20     in   INV_W  20-unit coins added
//  busy          out  1      request in progress
//  done          out  1      1-cycle pulse: full amount paid
//  short         out  1      1-cycle pulse: request ended with unpaid remainder
//  short_amount  out  W      unpaid remainder, held until the next request is loaded
//  overrun       out  1      1-cycle pulse: new request arrived while busy (dropped)
//  stock_10      out  INV_W  current 10-unit stock
//  stock_20      out  INV_W  current 20-unit stock
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; coin_valid/done/short/overrun/busy = 0;
//   coin_value, short_amount, remaining = 0; stock_10 = INIT_10; stock_20 = INIT_20.
//  Request detection: change_in_q registers change_in; request = change_in!=0 && change_in_q==0.
//  IDLE:   request -> remaining <= change_in, short_amount <= 0, busy <= 1, go SELECT.
//  SELECT: remaining>=20 && stock_20>0 -> coin_value<=20, coin_valid<=1, go ISSUE;
//          else remaining>=10 && stock_10>0 -> coin_value<=10, coin_valid<=1, go ISSUE;
//          else remaining==0 -> go DONE; else -> go SHORT.
//  ISSUE:  coin_valid held high, coin_value stable until coin_ready=1. On accepting edge:
//          remaining -= coin_value, matching stock -= 1, coin_valid<=0, coin_value<=0, go SELECT.
//  DONE:   done=1 for one cycle, busy<=0, go IDLE.
//  SHORT:  short=1 for one cycle, short_amount<=remaining, remaining<=0, busy<=0, go IDLE.
//  Latency: request at edge k -> coin_valid high after edge k+2; with coin_ready tied high,
//   one coin per 2 cycles; done/short is high the cycle after the last SELECT.
//  Amounts not a multiple of 10 always end in SHORT with the sub-10 remainder.
//  request while busy: ignored, overrun pulses 1 cycle; no state change. Note the edge
//   detector means a held nonzero change_in is never re-loaded after completion.
//  Refill: accepted in every state. Same-cycle refill and decrement: stock <= stock + refill - 1
//   computed at INV_W+1 bits, saturating at 2^INV_W-1. Stock never underflows (SELECT checks >0).
//  Reset mid-ISSUE: coin_valid drops immediately; the offered coin is treated as not paid.
// STRUCTURE
//  vend_pkg: COIN_10=16'd10, COIN_20=16'd20, typedef enum {IDLE,SELECT,ISSUE,DONE,SHORT}
//   disp_state_t; shared with the vending FSM bench.
//  Sub-module coin_stock (x2): saturating counter with INIT param, refill add, 1-coin decrement.
// TESTING
//  change_in=20 one cycle, ready=1 -> one coin 20, done pulse, stock_20 20->19, busy low.
//  change_in=10, stock_10=0, stock_20=5 -> no coin, short=1, short_amount=10.
//  change_in=25 -> coin 20 accepted, then short pulse with short_amount=5.
//  change_in=20, ready low 3 cycles -> coin_valid held 3 cycles, coin_value stays 20, one coin.
//  refill_20=255 on stock 20 with same-cycle dispense -> stock_20 saturates at 255.
//  rst asserted during ISSUE -> coin_valid 0 immediately, stocks back to 20/20; new request while
//   busy -> overrun pulse, original request completes unchanged.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin denominations and the
// dispenser state encoding. Also imported by benches that model the dispenser.
package change_dispenser_pkg;

  localparam logic [15:0] COIN_10 = 16'd10;
  localparam logic [15:0] COIN_20 = 16'd20;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StIssue,
    StDone,
    StShort
  } disp_state_t;

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle of the dispenser's request, hopper handshake, refill and status signals.
// Modports:
//   master - the dispenser: takes change_in, coin_ready and refill inputs, drives
//            the coin offer, status pulses and stock levels.
//   slave  - the surrounding machine / hopper driver side.
interface change_dispenser_if #(
  parameter int unsigned W     = 16,
  parameter int unsigned INV_W = 8
);

  logic [W-1:0]     change_in;
  logic             coin_valid;
  logic [W-1:0]     coin_value;
  logic             coin_ready;
  logic             refill_en;
  logic [INV_W-1:0] refill_10;
  logic [INV_W-1:0] refill_20;
  logic             busy;
  logic             done;
  logic             short;
  logic [W-1:0]     short_amount;
  logic             overrun;
  logic [INV_W-1:0] stock_10;
  logic [INV_W-1:0] stock_20;

  modport master (
    input  change_in, coin_ready, refill_en, refill_10, refill_20,
    output coin_valid, coin_value, busy, done, short, short_amount, overrun,
           stock_10, stock_20
  );

  modport slave (
    output change_in, coin_ready, refill_en, refill_10, refill_20,
    input  coin_valid, coin_value, busy, done, short, short_amount, overrun,
           stock_10, stock_20
  );

endinterface

// File: rtl/change_dispenser_coin_stock.sv
// Stock counter for one coin denomination.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (count returns to INIT)
//   refill_en - add refill to the count this cycle
//   refill    - number of coins added
//   take      - one coin leaves the stock this cycle
//   count     - current stock
// Refill and take in the same cycle combine as count + refill - 1, saturating at
// the counter maximum instead of wrapping.
module change_dispenser_coin_stock #(
  parameter int unsigned           INV_W = 8,
  parameter logic [INV_W-1:0]      INIT  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refill_en,
  input  logic [INV_W-1:0] refill,
  input  logic             take,
  output logic [INV_W-1:0] count
);

  logic [INV_W-1:0] count_q, count_d;
  logic [INV_W:0]   sum_add, sum;

  always_comb begin
    sum_add = {1'b0, count_q} + (refill_en ? {1'b0, refill} : '0);
    sum     = sum_add;
    // Guard keeps a stray take on an empty stock from wrapping into saturation.
    if (take && (sum_add != '0)) begin
      sum = sum_add - (INV_W + 1)'(1);
    end
    count_d = sum[INV_W] ? '1 : sum[INV_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= INIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: takes a change amount from the vending FSM and pays it out
// greedily as 20- and 10-unit coins over a valid/ready handshake to the hopper.
// Ports:
//   clk - system clock, rising edge
//   rst - asynchronous active-high reset
//   bus - change_dispenser_if.master: change_in request, coin_valid/coin_value/
//         coin_ready handshake, refill_en/refill_10/refill_20, busy, done, short,
//         short_amount, overrun, stock_10, stock_20
// A request is the rising edge of change_in away from zero; a request arriving
// while busy is dropped and flagged with an overrun pulse.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned      W       = 16,
  parameter int unsigned      INV_W   = 8,
  parameter logic [INV_W-1:0] INIT_10 = 8'd20,
  parameter logic [INV_W-1:0] INIT_20 = 8'd20
) (
  input logic                clk,
  input logic                rst,
  change_dispenser_if.master bus
);

  localparam logic [W-1:0] Val10 = W'(COIN_10);
  localparam logic [W-1:0] Val20 = W'(COIN_20);

  disp_state_t      state_q;
  logic [W-1:0]     change_in_q;
  logic [W-1:0]     remaining_q;
  logic             coin_valid_q;
  logic [W-1:0]     coin_value_q;
  logic             busy_q;
  logic             done_q;
  logic             short_q;
  logic [W-1:0]     short_amount_q;
  logic             overrun_q;

  logic             request;
  logic             accept;
  logic             take_10, take_20;
  logic [INV_W-1:0] stock_10, stock_20;

  assign request = (bus.change_in != '0) && (change_in_q == '0);
  assign accept  = (state_q == StIssue) && bus.coin_ready;
  assign take_20 = accept && (coin_value_q == Val20);
  assign take_10 = accept && (coin_value_q == Val10);

  change_dispenser_coin_stock #(
    .INV_W (INV_W),
    .INIT  (INIT_10)
  ) u_stock_10 (
    .clk       (clk),
    .rst       (rst),
    .refill_en (bus.refill_en),
    .refill    (bus.refill_10),
    .take      (take_10),
    .count     (stock_10)
  );

  change_dispenser_coin_stock #(
    .INV_W (INV_W),
    .INIT  (INIT_20)
  ) u_stock_20 (
    .clk       (clk),
    .rst       (rst),
    .refill_en (bus.refill_en),
    .refill    (bus.refill_20),
    .take      (take_20),
    .count     (stock_20)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      change_in_q    <= '0;
      remaining_q    <= '0;
      coin_valid_q   <= 1'b0;
      coin_value_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      short_q        <= 1'b0;
      short_amount_q <= '0;
      overrun_q      <= 1'b0;
    end else begin
      change_in_q <= bus.change_in;
      done_q      <= 1'b0;
      short_q     <= 1'b0;
      overrun_q   <= request && busy_q;

      unique case (state_q)
        StIdle: begin
          if (request) begin
            remaining_q    <= bus.change_in;
            short_amount_q <= '0;
            busy_q         <= 1'b1;
            state_q        <= StSelect;
          end
        end
        StSelect: begin
          if ((remaining_q >= Val20) && (stock_20 != '0)) begin
            coin_value_q <= Val20;
            coin_valid_q <= 1'b1;
            state_q      <= StIssue;
          end else if ((remaining_q >= Val10) && (stock_10 != '0)) begin
            coin_value_q <= Val10;
            coin_valid_q <= 1'b1;
            state_q      <= StIssue;
          end else if (remaining_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            // short pulses while in StShort, alongside the remainder it reports
            short_q        <= 1'b1;
            short_amount_q <= remaining_q;
            state_q        <= StShort;
          end
        end
        StIssue: begin
          if (bus.coin_ready) begin
            remaining_q  <= remaining_q - coin_value_q;
            coin_valid_q <= 1'b0;
            coin_value_q <= '0;
            state_q      <= StSelect;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        StShort: begin
          remaining_q <= '0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.coin_valid   = coin_valid_q;
  assign bus.coin_value   = coin_value_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.short        = short_q;
  assign bus.short_amount = short_amount_q;
  assign bus.overrun      = overrun_q;
  assign bus.stock_10     = stock_10;
  assign bus.stock_20     = stock_20;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: reset state, greedy payout, shortfall,
// handshake stall, saturating refill, overrun and asynchronous reset.
module tb_change_dispenser;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  int   coins;
  int   total;
  logic got_done;
  logic got_short;

  change_dispenser_if #(.W(16), .INV_W(8)) bus ();

  change_dispenser #(
    .W       (16),
    .INV_W   (8),
    .INIT_10 (8'd20),
    .INIT_20 (8'd20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Run until done or short shows, counting accepted coins; then return to idle.
  task automatic run_to_end(output int n, output logic d, output logic s);
    n = 0;
    d = 1'b0;
    s = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) begin
        d = 1'b1;
        break;
      end
      if (bus.short) begin
        s = 1'b1;
        break;
      end
      if (bus.coin_valid && bus.coin_ready) n++;
      step();
    end
    check("end_reached", 32'(d | s), 32'd1);
    step();
  endtask

  task automatic pay(input logic [15:0] amount, output int n, output logic d, output logic s);
    bus.change_in = amount;
    step();
    bus.change_in = '0;
    run_to_end(n, d, s);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    total          = 0;
    rst            = 1'b1;
    bus.change_in  = '0;
    bus.coin_ready = 1'b0;
    bus.refill_en  = 1'b0;
    bus.refill_10  = '0;
    bus.refill_20  = '0;
    step();
    step();

    // Reset state
    check("rst_valid", 32'(bus.coin_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_value", 32'(bus.coin_value), 32'd0);
    check("rst_short_amount", 32'(bus.short_amount), 32'd0);
    check("rst_stock_10", 32'(bus.stock_10), 32'd20);
    check("rst_stock_20", 32'(bus.stock_20), 32'd20);
    rst = 1'b0;
    step();

    // 20 with ready high: one 20 coin, done pulse
    bus.coin_ready = 1'b1;
    bus.change_in  = 16'd20;
    step();
    bus.change_in = '0;
    check("t1_busy", 32'(bus.busy), 32'd1);
    check("t1_no_offer_yet", 32'(bus.coin_valid), 32'd0);
    step();
    check("t1_valid", 32'(bus.coin_valid), 32'd1);
    check("t1_value", 32'(bus.coin_value), 32'd20);
    step();
    check("t1_valid_drop", 32'(bus.coin_valid), 32'd0);
    check("t1_stock_20", 32'(bus.stock_20), 32'd19);
    step();
    check("t1_done", 32'(bus.done), 32'd1);
    step();
    check("t1_done_pulse", 32'(bus.done), 32'd0);
    check("t1_busy_low", 32'(bus.busy), 32'd0);

    // Drain the 10s with twenty 10-unit requests
    for (int i = 0; i < 20; i++) begin
      pay(16'd10, coins, got_done, got_short);
      total += coins;
    end
    check("drain_coins", 32'(total), 32'd20);
    check("drain_stock_10", 32'(bus.stock_10), 32'd0);

    // 280 -> fourteen 20s, leaving five
    pay(16'd280, coins, got_done, got_short);
    check("p280_coins", 32'(coins), 32'd14);
    check("p280_done", 32'(got_done), 32'd1);
    check("p280_stock_20", 32'(bus.stock_20), 32'd5);

    // 10 with no 10s left -> short 10, no coin
    bus.change_in = 16'd10;
    step();
    bus.change_in = '0;
    step();
    check("t2_no_coin", 32'(bus.coin_valid), 32'd0);
    check("t2_short", 32'(bus.short), 32'd1);
    step();
    check("t2_short_pulse", 32'(bus.short), 32'd0);
    check("t2_short_amount", 32'(bus.short_amount), 32'd10);
    check("t2_busy_low", 32'(bus.busy), 32'd0);

    // 25 -> one 20, then short 5
    bus.change_in = 16'd25;
    step();
    bus.change_in = '0;
    check("t3_short_amount_cleared", 32'(bus.short_amount), 32'd0);
    step();
    check("t3_value", 32'(bus.coin_value), 32'd20);
    step();
    check("t3_stock_20", 32'(bus.stock_20), 32'd4);
    step();
    check("t3_short", 32'(bus.short), 32'd1);
    step();
    check("t3_short_amount", 32'(bus.short_amount), 32'd5);
    check("t3_busy_low", 32'(bus.busy), 32'd0);

    // 20 with ready low for 3 cycles: offer held and stable
    bus.coin_ready = 1'b0;
    bus.change_in  = 16'd20;
    step();
    bus.change_in = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_hold_valid", 32'(bus.coin_valid), 32'd1);
      check("t4_hold_value", 32'(bus.coin_value), 32'd20);
      check("t4_hold_stock", 32'(bus.stock_20), 32'd4);
    end
    bus.coin_ready = 1'b1;
    step();
    check("t4_valid_drop", 32'(bus.coin_valid), 32'd0);
    check("t4_stock_20", 32'(bus.stock_20), 32'd3);
    step();
    check("t4_done", 32'(bus.done), 32'd1);
    step();

    // Refill 255 in the same cycle as a 20 is taken: saturates
    bus.coin_ready = 1'b0;
    bus.change_in  = 16'd20;
    step();
    bus.change_in = '0;
    step();
    check("t5_valid", 32'(bus.coin_valid), 32'd1);
    bus.refill_en  = 1'b1;
    bus.refill_20  = 8'd255;
    bus.refill_10  = 8'd7;
    bus.coin_ready = 1'b1;
    step();
    bus.refill_en = 1'b0;
    check("t5_stock_20_sat", 32'(bus.stock_20), 32'd255);
    check("t5_stock_10", 32'(bus.stock_10), 32'd7);
    step();
    check("t5_done", 32'(bus.done), 32'd1);
    step();

    // 40 with a second request while busy: overrun, original completes
    bus.change_in = 16'd40;
    step();
    bus.change_in = '0;
    step();
    check("t6_valid", 32'(bus.coin_valid), 32'd1);
    bus.change_in = 16'd10;
    step();
    check("t6_overrun", 32'(bus.overrun), 32'd1);
    check("t6_stock_20_mid", 32'(bus.stock_20), 32'd254);
    bus.change_in = '0;
    step();
    check("t6_overrun_pulse", 32'(bus.overrun), 32'd0);
    run_to_end(coins, got_done, got_short);
    check("t6_coins_after", 32'(coins), 32'd1);
    check("t6_done", 32'(got_done), 32'd1);
    check("t6_stock_20", 32'(bus.stock_20), 32'd253);
    check("t6_stock_10", 32'(bus.stock_10), 32'd7);
    check("t6_busy_low", 32'(bus.busy), 32'd0);

    // Reset while a coin is offered: offer drops at once, stocks reload
    bus.coin_ready = 1'b0;
    bus.change_in  = 16'd20;
    step();
    bus.change_in = '0;
    step();
    check("t7_valid", 32'(bus.coin_valid), 32'd1);
    rst = 1'b1;
    #1;
    check("t7_valid_async", 32'(bus.coin_valid), 32'd0);
    check("t7_busy", 32'(bus.busy), 32'd0);
    check("t7_stock_10", 32'(bus.stock_10), 32'd20);
    check("t7_stock_20", 32'(bus.stock_20), 32'd20);
    step();
    rst            = 1'b0;
    bus.coin_ready = 1'b1;
    step();
    pay(16'd30, coins, got_done, got_short);
    check("t7_post_coins", 32'(coins), 32'd2);
    check("t7_post_done", 32'(got_done), 32'd1);
    check("t7_post_stock_20", 32'(bus.stock_20), 32'd19);
    check("t7_post_stock_10", 32'(bus.stock_10), 32'd19);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
